// File: rtl/trolley_system_pio_pkg.sv
// Shared definitions for the button-PIO servicer: FSM state encoding, PIO
// register map and the bus command each FSM state drives onto the PIO port.
package trolley_system_pio_pkg;

    typedef enum logic [2:0] {
        INIT_MASK = 3'd0,
        INIT_CLR  = 3'd1,
        IDLE      = 3'd2,
        RD_ADDR   = 3'd3,
        RD_DATA   = 3'd4,
        CLEAR     = 3'd5,
        HOLDOFF   = 3'd6
    } svc_state_e;

    // PIO register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    // Bus command presented while the FSM sits in the given state. Anything
    // that is not a bus cycle parks the port at its quiet values.
    function automatic bus_cmd_t bus_cmd_for(input svc_state_e st);
        bus_cmd_t cmd;
        cmd.cs    = 1'b0;
        cmd.wr_n  = 1'b1;
        cmd.addr  = ADDR_DATA;
        cmd.wdata = 32'd0;
        case (st)
            INIT_MASK: begin
                cmd.cs    = 1'b1;
                cmd.wr_n  = 1'b0;
                cmd.addr  = ADDR_MASK;
                cmd.wdata = 32'd1;
            end
            INIT_CLR, CLEAR: begin
                cmd.cs    = 1'b1;
                cmd.wr_n  = 1'b0;
                cmd.addr  = ADDR_EDGE;
                cmd.wdata = 32'd1;
            end
            RD_ADDR: begin
                cmd.cs    = 1'b1;
                cmd.addr  = ADDR_EDGE;
            end
            default: begin
                cmd.cs    = 1'b0;
            end
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/trolley_system_button_servicer.sv
// Button PIO servicer. Unmasks the button interrupt and clears stale edges
// after reset, then waits for the PIO interrupt (or a periodic poll), reads
// the edge-capture register, and on a captured edge clears it, emits one
// press pulse, bumps the press counter and locks out further presses for a
// debounce hold-off period.
//
// Ports:
//   clk, reset_n      single rising-edge clock, async active-low reset
//   enable            1 = service presses; 0 = park in IDLE once the current
//                     transfer / hold-off has finished
//   irq               level interrupt from the button PIO
//   readdata[31:0]    PIO read data, one clock after the read address
//   address[1:0], chipselect, write_n, writedata[31:0]   PIO bus (registered)
//   press_pulse       one-clock pulse per accepted press (registered)
//   press_count[15:0] accepted presses, wraps at 16'hFFFF
//   busy              1 whenever the FSM is outside IDLE
module trolley_system_button_servicer
    import trolley_system_pio_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = 50000,
    parameter int unsigned HOLDOFF_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        irq,
    input  logic [31:0] readdata,
    output logic [1:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [31:0] writedata,
    output logic        press_pulse,
    output logic [15:0] press_count,
    output logic        busy
);

    localparam logic [19:0] POLL_LAST = 20'(POLL_CYCLES - 32'd1);
    localparam logic [19:0] HOLD_LAST = (HOLDOFF_CYCLES == 32'd0) ? 20'd0
                                                                  : 20'(HOLDOFF_CYCLES - 32'd1);
    localparam logic        HOLD_SKIP = (HOLDOFF_CYCLES == 32'd0);

    svc_state_e  state_r;
    svc_state_e  state_next_s;
    logic        init_go_r;
    logic [19:0] poll_cnt_r;
    logic [19:0] hold_cnt_r;
    bus_cmd_t    bus_next_s;

    logic        chipselect_r;
    logic        write_n_r;
    logic [1:0]  address_r;
    logic [31:0] writedata_r;
    logic        press_pulse_r;
    logic [15:0] press_count_r;
    logic        busy_r;

    // Only bit 0 (the single button's edge flag) is meaningful.
    logic        rd_unused_s;
    assign rd_unused_s = ^readdata[31:1];

    // Next-state logic. Outputs are registered from the next state so that the
    // bus command is on the wires during the very clock the FSM is in that
    // state; that alignment is what lets RD_DATA sample the read data exactly
    // one clock after RD_ADDR presented the address.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT_MASK: begin
                // The first clock after reset release only loads the mask
                // write into the output registers.
                if (init_go_r) begin
                    state_next_s = INIT_CLR;
                end else begin
                    state_next_s = INIT_MASK;
                end
            end
            INIT_CLR: begin
                state_next_s = IDLE;
            end
            IDLE: begin
                // irq and poll expiry together still produce a single read.
                if (enable && (irq || (poll_cnt_r == POLL_LAST))) begin
                    state_next_s = RD_ADDR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_ADDR: begin
                state_next_s = RD_DATA;
            end
            RD_DATA: begin
                if (readdata[0]) begin
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: begin
                if (HOLD_SKIP) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLDOFF;
                end
            end
            HOLDOFF: begin
                // irq is deliberately ignored; a new edge stays latched in
                // the PIO and is picked up from IDLE afterwards.
                if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLDOFF;
                end
            end
            default: begin
                state_next_s = INIT_MASK;
            end
        endcase
        bus_next_s = bus_cmd_for(state_next_s);
    end

    // State register and reset-release flag for the init sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= INIT_MASK;
            init_go_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            init_go_r <= 1'b1;
        end
    end

    // Poll counter: runs while staying in IDLE, restarts on every IDLE entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt_r <= 20'd0;
        end else if ((state_r == IDLE) && (state_next_s == IDLE)) begin
            poll_cnt_r <= (poll_cnt_r == POLL_LAST) ? 20'd0 : poll_cnt_r + 20'd1;
        end else begin
            poll_cnt_r <= 20'd0;
        end
    end

    // Hold-off counter: counts clocks spent in HOLDOFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_r <= 20'd0;
        end else if ((state_r == HOLDOFF) && (state_next_s == HOLDOFF)) begin
            hold_cnt_r <= hold_cnt_r + 20'd1;
        end else begin
            hold_cnt_r <= 20'd0;
        end
    end

    // Registered bus port, press pulse and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chipselect_r  <= 1'b0;
            write_n_r     <= 1'b1;
            address_r     <= ADDR_DATA;
            writedata_r   <= 32'd0;
            press_pulse_r <= 1'b0;
            busy_r        <= 1'b1;
        end else begin
            chipselect_r  <= bus_next_s.cs;
            write_n_r     <= bus_next_s.wr_n;
            address_r     <= bus_next_s.addr;
            writedata_r   <= bus_next_s.wdata;
            press_pulse_r <= (state_next_s == CLEAR);
            busy_r        <= (state_next_s != IDLE);
        end
    end

    // Press counter, advanced in the same clock as the clear write; wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_count_r <= 16'd0;
        end else if (state_next_s == CLEAR) begin
            press_count_r <= press_count_r + 16'd1;
        end
    end

    assign chipselect  = chipselect_r;
    assign write_n     = write_n_r;
    assign address     = address_r;
    assign writedata   = writedata_r;
    assign press_pulse = press_pulse_r;
    assign press_count = press_count_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_trolley_system_button_servicer.sv
// Scoreboard bench for trolley_system_button_servicer with a small button
// PIO model. Stimulus pushes expected bus cycles, press events and status
// snapshots (each tagged with the clock number it must appear in); a
// monitor samples the DUT on every falling edge and checks them.
module tb_trolley_system_button_servicer;

    localparam int POLL = 8;
    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        irq;
    logic [31:0] readdata = 32'd0;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        press_pulse;
    logic [15:0] press_count;
    logic        busy;

    logic btn = 1'b0;
    logic irq_gate = 1'b0;
    logic edge_r = 1'b0;
    logic mask_r = 1'b0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    typedef struct {int cyc; logic wr_n; logic [1:0] addr; logic [31:0] wdata;} bus_exp_t;
    typedef struct {int cyc; logic [15:0] cnt;} press_exp_t;
    typedef struct {int cyc; logic busy; logic [15:0] cnt;} stat_exp_t;

    bus_exp_t   bus_q[$];
    press_exp_t press_q[$];
    stat_exp_t  stat_q[$];

    trolley_system_button_servicer #(
        .POLL_CYCLES(POLL),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .irq(irq),
        .readdata(readdata),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .press_pulse(press_pulse),
        .press_count(press_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Button PIO model: edge capture, irq mask, read latency of one clock.
    always @(posedge clk) begin
        if (chipselect && !write_n && address == 2'd2) mask_r <= writedata[0];
        if (btn) edge_r <= 1'b1;
        else if (chipselect && !write_n && address == 2'd3 && writedata[0]) edge_r <= 1'b0;
        readdata <= (chipselect && write_n && address == 2'd3) ? {31'd0, edge_r} : 32'd0;
    end

    assign irq = mask_r & edge_r & irq_gate;

    function automatic void exp_rd(int c);
        bus_q.push_back('{c, 1'b1, 2'd3, 32'd0});
    endfunction

    function automatic void exp_wr(int c, logic [1:0] a);
        bus_q.push_back('{c, 1'b0, a, 32'd1});
    endfunction

    function automatic void exp_press(int c, logic [15:0] n);
        press_q.push_back('{c, n});
    endfunction

    function automatic void exp_stat(int c, logic b, logic [15:0] n);
        stat_q.push_back('{c, b, n});
    endfunction

    task automatic at(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press_btn();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        bus_exp_t   be;
        press_exp_t pe;
        stat_exp_t  se;
        forever begin
            @(negedge clk);
            if (chipselect !== 1'b0) begin
                n_cmp = n_cmp + 1;
                if (bus_q.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL bus_unexpected: got cyc=%0d wr_n=%0b addr=%0d data=0x%08h, expected no bus cycle",
                             cyc, write_n, address, writedata);
                end else begin
                    be = bus_q.pop_front();
                    if (cyc != be.cyc || write_n !== be.wr_n || address !== be.addr || writedata !== be.wdata) begin
                        n_bad = n_bad + 1;
                        $display("FAIL bus_cycle: got cyc=%0d wr_n=%0b addr=%0d data=0x%08h, expected cyc=%0d wr_n=%0b addr=%0d data=0x%08h",
                                 cyc, write_n, address, writedata, be.cyc, be.wr_n, be.addr, be.wdata);
                    end
                end
            end else begin
                n_cmp = n_cmp + 1;
                if (write_n !== 1'b1 || address !== 2'd0 || writedata !== 32'd0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL bus_quiet: cyc=%0d got wr_n=%0b addr=%0d data=0x%08h, expected 1/0/0",
                             cyc, write_n, address, writedata);
                end
            end
            if (press_pulse !== 1'b0) begin
                n_cmp = n_cmp + 1;
                if (press_q.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL press_unexpected: got pulse=%0b at cyc=%0d count=%0d, expected no pulse",
                             press_pulse, cyc, press_count);
                end else begin
                    pe = press_q.pop_front();
                    if (cyc != pe.cyc || press_count !== pe.cnt) begin
                        n_bad = n_bad + 1;
                        $display("FAIL press_event: got cyc=%0d count=0x%04h, expected cyc=%0d count=0x%04h",
                                 cyc, press_count, pe.cyc, pe.cnt);
                    end
                end
            end
            if (stat_q.size() != 0 && stat_q[0].cyc == cyc) begin
                se = stat_q.pop_front();
                n_cmp = n_cmp + 1;
                if (busy !== se.busy || press_count !== se.cnt) begin
                    n_bad = n_bad + 1;
                    $display("FAIL status: cyc=%0d got busy=%0b count=0x%04h, expected busy=%0b count=0x%04h",
                             cyc, busy, press_count, se.busy, se.cnt);
                end
            end
            if (end_req && !end_done) begin
                n_cmp = n_cmp + 1;
                if (bus_q.size() != 0 || press_q.size() != 0 || stat_q.size() != 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL leftover: got %0d bus / %0d press / %0d status pending, expected 0/0/0",
                             bus_q.size(), press_q.size(), stat_q.size());
                end
                end_done = 1'b1;
            end
        end
    end

    // Directed stimulus; r is the clock count at reset release.
    initial begin : stim
        int r;
        int rel;
        exp_stat(2, 1'b1, 16'd0);
        repeat (3) @(negedge clk);
        r = cyc;

        // Init: mask write, then edge-capture clear, then IDLE.
        exp_wr(r + 1, 2'd2);
        exp_wr(r + 2, 2'd3);
        exp_stat(r + 3, 1'b0, 16'd0);
        enable  = 1'b1;
        reset_n = 1'b1;

        // Edge with irq blocked: found by the poll read 8 clocks into IDLE.
        at(r + 3);
        exp_rd(r + 11);
        exp_wr(r + 13, 2'd3);
        exp_press(r + 13, 16'd1);
        exp_stat(r + 20, 1'b1, 16'd1);
        press_btn();

        // Edge during hold-off: quiet for 16 clocks, then served by irq.
        at(r + 15);
        irq_gate = 1'b1;
        exp_rd(r + 31);
        exp_wr(r + 33, 2'd3);
        exp_press(r + 33, 16'd2);
        press_btn();

        // irq in IDLE: read starts on the next clock.
        at(r + 52);
        exp_rd(r + 54);
        exp_wr(r + 56, 2'd3);
        exp_press(r + 56, 16'd3);
        press_btn();

        // irq rises exactly when the poll count expires: one read only.
        at(r + 79);
        exp_rd(r + 81);
        exp_wr(r + 83, 2'd3);
        exp_press(r + 83, 16'd4);
        press_btn();

        // Preload the press counter to its maximum during hold-off.
        at(r + 90);
        exp_stat(r + 92, 1'b1, 16'hFFFF);
        force dut.press_count_r = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.press_count_r;

        // Wrapping press, with enable dropped mid-transfer.
        at(r + 101);
        exp_rd(r + 103);
        exp_wr(r + 105, 2'd3);
        exp_press(r + 105, 16'd0);
        exp_stat(r + 150, 1'b0, 16'd0);
        press_btn();
        at(r + 104);
        enable = 1'b0;

        // Disabled: stays quiet in IDLE; then reset during RD_DATA.
        at(r + 150);
        exp_rd(r + 153);
        exp_stat(r + 154, 1'b1, 16'd0);
        press_btn();
        at(r + 152);
        enable = 1'b1;
        at(r + 153);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;

        at(r + 157);
        rel = cyc;
        exp_wr(rel + 1, 2'd2);
        exp_wr(rel + 2, 2'd3);
        exp_stat(rel + 3, 1'b0, 16'd0);
        reset_n = 1'b1;

        at(rel + 20);
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_done; i++) @(negedge clk);
        @(negedge clk);
        if (!end_done) begin
            $display("FAIL end_handshake: got done=%0b, expected 1", end_done);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        end else begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        end
        $finish;
    end

endmodule
